// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern source: mode codes, colour-bar table and
// frame-total helper.
package vga_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] MODE_BLACK       = 4'd0;
  localparam logic [3:0] MODE_WHITE       = 4'd1;
  localparam logic [3:0] MODE_RED         = 4'd2;
  localparam logic [3:0] MODE_GREEN       = 4'd3;
  localparam logic [3:0] MODE_BLUE        = 4'd4;
  localparam logic [3:0] MODE_GRID_FINE   = 4'd5;
  localparam logic [3:0] MODE_GRID_COARSE = 4'd6;
  localparam logic [3:0] MODE_XRAMP       = 4'd7;
  localparam logic [3:0] MODE_YRAMP       = 4'd8;
  localparam logic [3:0] MODE_RRAMP       = 4'd9;
  localparam logic [3:0] MODE_GRAMP       = 4'd10;
  localparam logic [3:0] MODE_BRAMP       = 4'd11;
  localparam logic [3:0] MODE_BARS        = 4'd12;
  localparam logic [3:0] MODE_WRAP        = 4'd13;

  function automatic int tot4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  function automatic logic [15:0] bar_rgb565(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hF800;
      3'd1:    return 16'h07E0;
      3'd2:    return 16'h001F;
      3'd3:    return 16'hF81F;
      3'd4:    return 16'hFFE0;
      3'd5:    return 16'h07FF;
      3'd6:    return 16'hFFFF;
      default: return 16'hFC00;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and combinational decode of sync, active region, active-area
// offsets and the frame-start condition; the caller registers everything.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_SYNC   = 136,
  parameter int H_BACK   = 160,
  parameter int H_ACTIVE = 1024,
  parameter int H_FRONT  = 24,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 29,
  parameter int V_ACTIVE = 768,
  parameter int V_FRONT  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_hs_act,
  output logic             o_vs_act,
  output logic             o_de,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_x_act,
  output logic [CNT_W-1:0] o_y_act
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(tot4(H_SYNC, H_BACK, H_ACTIVE, H_FRONT) - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(tot4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT) - 1);
  localparam logic [CNT_W-1:0] H_SY   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
    end else begin
      r_h <= r_h + CNT_W'(1);
    end
  end

  assign o_hs_act      = (r_h < H_SY);
  assign o_vs_act      = (r_v < V_SY);
  assign o_de          = (r_h >= H_AS) && (r_h < H_AE) && (r_v >= V_AS) && (r_v < V_AE);
  assign o_frame_start = (r_h == '0) && (r_v == '0);
  assign o_x_act       = r_h - H_AS;
  assign o_y_act       = r_v - V_AS;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: key debounce, frame-aligned mode switching, pattern
// mux and output register stage. Define VGA_BORDER_EN to force a white outline.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC       = 136,
  parameter int H_BACK       = 160,
  parameter int H_ACTIVE     = 1024,
  parameter int H_FRONT      = 24,
  parameter int V_SYNC       = 6,
  parameter int V_BACK       = 29,
  parameter int V_ACTIVE     = 768,
  parameter int V_FRONT      = 3,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0,
  parameter int R_W          = 5,
  parameter int G_W          = 6,
  parameter int B_W          = 5,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int GRID_FINE    = 4,
  parameter int GRID_COARSE  = 6,
  parameter int GRAD_SHIFT   = 1
) (
  input  logic           vga_clk,
  input  logic           rst,
  input  logic           key,
  input  logic           mode_ld,
  input  logic [3:0]     mode_in,
  output logic [3:0]     mode_q,
  output logic           frame_start,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           vga_de,
  output logic [R_W-1:0] vga_r,
  output logic [G_W-1:0] vga_g,
  output logic [B_W-1:0] vga_b
);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = (HS_POL == 0);
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = (VS_POL == 0);
  localparam int   DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]  DB_FIRE = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]  DB_SAT  = DB_W'(DEBOUNCE_CYC);
  localparam int               BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`ifdef VGA_BORDER_EN
  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);
`endif

  // Expand a 5/6-bit table channel to the configured width by bit replication.
  function automatic logic [R_W-1:0] scale_r(input logic [4:0] v);
    logic [19:0] rep;
    rep = {4{v}};
    return R_W'(rep >> (20 - R_W));
  endfunction

  function automatic logic [G_W-1:0] scale_g(input logic [5:0] v);
    logic [17:0] rep;
    rep = {3{v}};
    return G_W'(rep >> (18 - G_W));
  endfunction

  function automatic logic [B_W-1:0] scale_b(input logic [4:0] v);
    logic [19:0] rep;
    rep = {4{v}};
    return B_W'(rep >> (20 - B_W));
  endfunction

  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de;
  logic             w_fs;
  logic [CNT_W-1:0] w_x_act;
  logic [CNT_W-1:0] w_y_act;

  vga_timing #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_ACTIVE(H_ACTIVE),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_ACTIVE(V_ACTIVE),
    .V_FRONT (V_FRONT)
  ) u_timing (
    .i_clk        (vga_clk),
    .i_rst        (rst),
    .o_hs_act     (w_hs_act),
    .o_vs_act     (w_vs_act),
    .o_de         (w_de),
    .o_frame_start(w_fs),
    .o_x_act      (w_x_act),
    .o_y_act      (w_y_act)
  );

  // Key synchroniser and debounce: one step per press, re-armed on release.
  logic            r_key_s1;
  logic            r_key_s2;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_step;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_key_s1 <= 1'b0;
      r_key_s2 <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      if (!r_key_s2)
        r_db_cnt <= '0;
      else if (r_db_cnt != DB_SAT)
        r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_step = r_key_s2 && (r_db_cnt == DB_FIRE);

  logic       r_pend;
  logic [3:0] r_pend_mode;
  logic [3:0] r_mode;
  logic [3:0] w_base;
  logic [3:0] w_step_mode;
  logic       w_req;
  logic [3:0] w_req_mode;

  assign w_base      = r_pend ? r_pend_mode : r_mode;
  assign w_step_mode = (w_base >= MODE_WRAP) ? 4'd0 : w_base + 4'd1;
  assign w_req       = mode_ld | w_step;
  assign w_req_mode  = mode_ld ? mode_in : w_step_mode;

  // A request landing on the boundary cycle takes effect at that same boundary.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_BLACK;
      r_pend      <= 1'b0;
      r_pend_mode <= MODE_BLACK;
    end else if (w_fs) begin
      if (w_req)
        r_mode <= w_req_mode;
      else if (r_pend)
        r_mode <= r_pend_mode;
      r_pend <= 1'b0;
    end else if (w_req) begin
      r_pend      <= 1'b1;
      r_pend_mode <= w_req_mode;
    end
  end

  assign mode_q = r_mode;

  logic [R_W-1:0]   w_r;
  logic [G_W-1:0]   w_g;
  logic [B_W-1:0]   w_b;
  logic [CNT_W-1:0] w_bar_q;
  logic [2:0]       w_bar;
  logic [15:0]      w_bar_c;

  always_comb begin
    w_r     = '0;
    w_g     = '0;
    w_b     = '0;
    w_bar_q = w_x_act / CNT_W'(BAR_W);
    w_bar   = (w_bar_q > CNT_W'(7)) ? 3'd7 : w_bar_q[2:0];
    w_bar_c = bar_rgb565(w_bar);
    case (r_mode)
      MODE_BLACK: begin end
      MODE_RED:   w_r = '1;
      MODE_GREEN: w_g = '1;
      MODE_BLUE:  w_b = '1;
      MODE_GRID_FINE: begin
        if (!(w_x_act[GRID_FINE] ^ w_y_act[GRID_FINE])) begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
      end
      MODE_GRID_COARSE: begin
        if (!(w_x_act[GRID_COARSE] ^ w_y_act[GRID_COARSE])) begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
      end
      MODE_XRAMP: begin
        w_r = R_W'(w_x_act >> GRAD_SHIFT);
        w_g = G_W'(w_x_act >> GRAD_SHIFT);
        w_b = B_W'(w_x_act >> GRAD_SHIFT);
      end
      MODE_YRAMP: begin
        w_r = R_W'(w_y_act >> GRAD_SHIFT);
        w_g = G_W'(w_y_act >> GRAD_SHIFT);
        w_b = B_W'(w_y_act >> GRAD_SHIFT);
      end
      MODE_RRAMP: w_r = R_W'(w_x_act >> GRAD_SHIFT);
      MODE_GRAMP: w_g = G_W'(w_x_act >> GRAD_SHIFT);
      MODE_BRAMP: w_b = B_W'(w_x_act >> GRAD_SHIFT);
      MODE_BARS: begin
        w_r = scale_r(w_bar_c[15:11]);
        w_g = scale_g(w_bar_c[10:5]);
        w_b = scale_b(w_bar_c[4:0]);
      end
      default: begin
        w_r = '1;
        w_g = '1;
        w_b = '1;
      end
    endcase
`ifdef VGA_BORDER_EN
    if ((w_x_act == '0) || (w_x_act == X_LAST) || (w_y_act == '0) || (w_y_act == Y_LAST)) begin
      w_r = '1;
      w_g = '1;
      w_b = '1;
    end
`endif
  end

  // Output stage: every video output lags the counters by exactly one clock.
  logic           r_hs_p1;
  logic           r_vs_p1;
  logic           r_de_p1;
  logic           r_fs_p1;
  logic [R_W-1:0] r_red_p1;
  logic [G_W-1:0] r_grn_p1;
  logic [B_W-1:0] r_blu_p1;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_hs_p1  <= HS_OFF;
      r_vs_p1  <= VS_OFF;
      r_de_p1  <= 1'b0;
      r_fs_p1  <= 1'b0;
      r_red_p1 <= '0;
      r_grn_p1 <= '0;
      r_blu_p1 <= '0;
    end else begin
      r_hs_p1  <= w_hs_act ? HS_ON : HS_OFF;
      r_vs_p1  <= w_vs_act ? VS_ON : VS_OFF;
      r_de_p1  <= w_de;
      r_fs_p1  <= w_fs;
      r_red_p1 <= w_de ? w_r : '0;
      r_grn_p1 <= w_de ? w_g : '0;
      r_blu_p1 <= w_de ? w_b : '0;
    end
  end

  assign vga_hs      = r_hs_p1;
  assign vga_vs      = r_vs_p1;
  assign vga_de      = r_de_p1;
  assign frame_start = r_fs_p1;
  assign vga_r       = r_red_p1;
  assign vga_g       = r_grn_p1;
  assign vga_b       = r_blu_p1;

endmodule
